// File: rtl/lut_neuron_table_loader_if.sv
// Config-stream and lookup bundle between the layer loader and one neuron slot.
interface lut_neuron_table_loader_if #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_last;
    logic                cfg_clear;
    logic                in_valid;
    logic [IN_BITS-1:0]  M0;
    logic                out_valid;
    logic [OUT_BITS-1:0] M1;
    logic                loaded;
    logic                cfg_err;
    logic                lookup_drop;

    modport master (
        output cfg_valid, cfg_data, cfg_last, cfg_clear, in_valid, M0,
        input  cfg_ready, out_valid, M1, loaded, cfg_err, lookup_drop
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, cfg_clear, in_valid, M0,
        output cfg_ready, out_valid, M1, loaded, cfg_err, lookup_drop
    );
endinterface

// File: rtl/lut_neuron_table_loader.sv
// Runtime-loadable neuron truth table: streamed writer plus 1-cycle registered lookup.
module lut_neuron_table_loader #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2
) (
    input logic                      clk,
    input logic                      rst,
    lut_neuron_table_loader_if.slave bus
);
    localparam int unsigned        DEPTH    = 1 << IN_BITS;
    localparam logic [IN_BITS-1:0] LAST_IDX = IN_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, ERROR} state_t;

    state_t              state;
    state_t              next_state;
    logic [IN_BITS-1:0]  wr_cnt;
    logic [OUT_BITS-1:0] mem [DEPTH];

    logic                xfer;
    logic                at_last;
    logic                wr_en;
    logic                serve;
    logic                drop;

    logic                cfg_ready_q;
    logic                loaded_q;
    logic                cfg_err_q;
    logic                out_valid_q;
    logic                lookup_drop_q;
    logic [OUT_BITS-1:0] m1_q;

    // cfg_ready_q mirrors "state is IDLE or LOAD", so it is the accept qualifier
    assign xfer    = bus.cfg_valid && cfg_ready_q;
    assign at_last = (wr_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: clear wins; a beat either continues, completes, or is malformed
    always_comb begin
        next_state = state;
        if (bus.cfg_clear) begin
            next_state = IDLE;
        end else if (xfer) begin
            if (bus.cfg_last) begin
                next_state = at_last ? ACTIVE : ERROR;
            end else begin
                next_state = at_last ? ERROR : LOAD;
            end
        end
    end

    // Per-cycle controls decoded from the current (pre-clear) state
    always_comb begin
        wr_en = 1'b0;
        serve = 1'b0;
        drop  = 1'b0;
        wr_en = xfer && !bus.cfg_clear;
        serve = bus.in_valid && (state == ACTIVE);
        drop  = bus.in_valid && (state != ACTIVE);
    end

    // Status flags registered from the next state so they track the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ready_q <= 1'b1;
            loaded_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_ready_q <= (next_state == IDLE) || (next_state == LOAD);
            loaded_q    <= (next_state == ACTIVE);
            cfg_err_q   <= (next_state == ERROR);
        end
    end

    // Write counter: saturates at the last index so it never starts a second pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (bus.cfg_clear) begin
            wr_cnt <= '0;
        end else if (wr_en && !at_last) begin
            wr_cnt <= wr_cnt + IN_BITS'(1);
        end
    end

    // Table write port; no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt] <= bus.cfg_data;
        end
    end

    // Lookup pipeline: asynchronous table read captured into the result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_q          <= '0;
            out_valid_q   <= 1'b0;
            lookup_drop_q <= 1'b0;
        end else begin
            out_valid_q   <= serve;
            lookup_drop_q <= drop;
            if (serve) begin
                m1_q <= mem[bus.M0];
            end
        end
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.loaded      = loaded_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.lookup_drop = lookup_drop_q;
    assign bus.M1          = m1_q;
endmodule

// File: doc/lut_neuron_table_loader.md
Name: lut_neuron_table_loader

Overview:
- Runtime-programmable LogicNets neuron: a distributed-RAM truth table that the configuration stream writes and the inference datapath reads.
- Fixed neurons are synthesized ROMs. This block is their writer end: it accepts a streamed truth table (one OUT_BITS code per input pattern), tracks load completeness, then serves single-cycle registered lookups.
- Sits between the layer-config stream and one neuron slot of a layer. Each layer instantiates one per neuron.

Parameters:
IN_BITS, 8, concatenated neuron input width (fan-in × input bitwidth); legal 1..12
OUT_BITS, 2, quantized neuron output width; legal 1..8
DEPTH, 2**IN_BITS, derived table depth; not overridable

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config beat valid
cfg_ready  out  1  config beat accepted when high with cfg_valid
cfg_data  in  OUT_BITS  table entry for address = current write count
cfg_last  in  1  marks final entry (address DEPTH-1)
cfg_clear  in  1  single-cycle pulse: discard table, return to IDLE
in_valid  in  1  lookup request
M0  in  IN_BITS  lookup address (neuron input vector)
out_valid  out  1  lookup result valid
M1  out  OUT_BITS  neuron output code
loaded  out  1  table complete and serving
cfg_err  out  1  malformed load detected
lookup_drop  out  1  one-cycle pulse: in_valid seen while not ACTIVE

Behaviour:
- States: IDLE, LOAD, ACTIVE, ERROR. Registers: state, wr_cnt[IN_BITS-1:0] (IN_BITS+1 bits if needed for compare), M1, out_valid, lookup_drop, and the DEPTH×OUT_BITS table.
- Reset (async, any state, including mid-load) sets:
  - state=IDLE, wr_cnt=0
  - M1=0, out_valid=0, lookup_drop=0
  - loaded=0, cfg_err=0, cfg_ready=1
  - Table contents are not cleared; they are unreachable until reloaded.
- Outputs decoded from state:
  - cfg_ready=1 in IDLE and LOAD only.
  - loaded=1 iff ACTIVE.
  - cfg_err=1 iff ERROR.
- A beat transfers when cfg_valid && cfg_ready. On each transfer, table[wr_cnt] <= cfg_data. Entry k is returned for M0 == k (unsigned).
- IDLE: a transfer writes entry 0 and sets wr_cnt=1.
  - DEPTH==1 with cfg_last → ACTIVE.
  - Otherwise cfg_last → ERROR; no cfg_last → LOAD.
- LOAD: each transfer writes table[wr_cnt] and increments wr_cnt.
  - cfg_last on the beat with wr_cnt<DEPTH-1 (early last) → ERROR.
  - Beat at wr_cnt==DEPTH-1 with cfg_last → ACTIVE.
  - Beat at wr_cnt==DEPTH-1 without cfg_last → ERROR. wr_cnt never wraps into a second pass.
  - cfg_valid gaps stall; wr_cnt advances only on transfer.
- ACTIVE: cfg_ready=0; config beats are ignored (not consumed).
- ERROR: cfg_ready=0; all lookups dropped; exit only via cfg_clear or rst.
- cfg_clear in any state → IDLE next cycle with wr_cnt=0. It has priority over a same-cycle transfer (the beat is not written). In IDLE it is a no-op.
- Lookup, latency 1:
  - If in_valid && state==ACTIVE at edge N: at N+1, out_valid=1 and M1=table[M0 sampled at N].
  - Otherwise out_valid=0 and M1 holds its last value.
  - Back-to-back lookups give one result per cycle. No backpressure on the lookup side.
- lookup_drop: =1 for one cycle after any edge where in_valid && state!=ACTIVE.
- A lookup in the same cycle as cfg_clear while ACTIVE is served (state sampled pre-clear).
- A lookup is never served in the cycle the last beat is written; the first servable lookup is one cycle after loaded rises.
- Table read is asynchronous into the M1 register, for LUTRAM inference. Single write port, driven only outside ACTIVE, so there is no read/write collision.

Test Plan:
- Full load, IN_BITS=8, entry k = k[1:0], cfg_last on beat 255 → loaded=1 the cycle after beat 255. Lookup M0=8'hB6 → next cycle out_valid=1, M1=2'b10. Back-to-back M0=8'h03,8'hFC → M1=2'b11 then 2'b00 on consecutive cycles.
- Early cfg_last on beat index 100 → cfg_err=1, cfg_ready=0, loaded=0. A following in_valid → lookup_drop pulses 1 cycle and out_valid stays 0.
- 256 beats with no cfg_last → cfg_err=1 after beat 255. The 257th cfg_valid is not accepted (cfg_ready=0).
- Load with cfg_valid toggling every other cycle plus 10-cycle gaps → wr_cnt counts transfers only. Loaded table is byte-exact against the reference pattern (all 256 addresses swept by lookups).
- While ACTIVE, pulse cfg_clear → IDLE, loaded=0. Reload with entry k = ~k[1:0] → M0=8'hB6 returns 2'b01.
- Assert rst at beat 50 mid-load → all outputs reset immediately (async). Fresh 256-beat load after release → loaded=1, correct contents.
